operand_loader: RTL and testbench
=================================

Name: operand_loader

Overview:
Upstream stage of the 1024-bit large-number multiplier. It receives both operands as a narrow word stream over a valid/ready handshake and assembles them into two full-width registers. When both registers are complete it presents them to the multiplier, asserts op_valid, and holds both operands stable until the consumer acknowledges. This lets the wide multiplier be fed from a 32-bit bus or source FIFO instead of 2048 parallel input bits.

Parameters:
WORD_W, 32, stream word width in bits.
OP_W, 1024, width of each operand; must be an integer multiple of WORD_W.
NWORDS, OP_W/WORD_W (32), words per operand; derived, not overridden.

Ports:
clk  input  1  single system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
clear  input  1  synchronous abort: discard any partial or complete load.
in_data  input  WORD_W  stream word.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader can accept a word (registered).
In1  output  OP_W  operand A, direct to the multiplier's In1.
In2  output  OP_W  operand B, direct to the multiplier's In2.
op_valid  output  1  In1 and In2 are complete and stable.
op_ack  input  1  consumer has taken the operands.
busy  output  1  at least one word of the current pair has been accepted, op_valid not yet set.

Behaviour:
- Reset (rstn low, asynchronous): state LOAD_A, word_cnt 0, In1 0, In2 0, op_valid 0, in_ready 0, busy 0.
- First rising edge after rstn deasserts: in_ready goes to 1.
- Accept condition: in_valid & in_ready & !clear. No word is taken on any other cycle.
- Word placement: the k-th accepted word of an operand (k = 0..NWORDS-1) is written to bits [k*WORD_W +: WORD_W]. Words arrive least-significant first. Bits not yet written keep their previous values.
- State LOAD_A: an accepted word is written into In1 and word_cnt increments. When the accepted word has word_cnt = NWORDS-1, word_cnt wraps to 0 and the state moves to LOAD_B.
- State LOAD_B: the same rules apply, writing into In2. On the last word the state moves to HOLD; op_valid rises on the same edge and in_ready falls on the same edge.
- State HOLD: in_ready = 0, op_valid = 1, In1 and In2 are frozen, in_valid is ignored.
  - op_ack = 1 moves the state to LOAD_A; op_valid falls and in_ready rises on the same edge.
  - Operands keep their values until overwritten by the next load.
  - op_ack outside HOLD is ignored.
- Throughput: one word per cycle with no bubbles. The minimum time from the first accepted word to op_valid is 2*NWORDS edges (64). Gaps in in_valid only stall the loader.
- busy = (state is LOAD_A or LOAD_B) and (word_cnt != 0 or state is LOAD_B).
- clear = 1 (synchronous, in any state):
  - next state LOAD_A, word_cnt 0, In1 0, In2 0, op_valid 0, in_ready 1.
  - clear beats in_valid: a word offered in that cycle is dropped. The source must also be flushed by the controller.
  - clear beats op_ack.
- Reset mid-load or in HOLD: immediate return to the reset values; partial data is lost.
- word_cnt width is clog2(NWORDS). A wrap is allowed only on the last-word transition.

Test Plan:
1. Stream 33, then 31 zeros, then 44, then 31 zeros, with in_valid held high -> after the 64th accept, op_valid = 1 on the next edge, In1 = 1024'd33, In2 = 1024'd44, in_ready = 0. With the multiplier attached, Out = 2048'd1452.
2. Same stream with in_valid low on every other cycle -> identical In1/In2, op_valid asserts after 128 cycles, no word lost or duplicated.
3. In HOLD, drive in_valid = 1 with in_data = 32'hFFFFFFFF for 10 cycles, then assert op_ack -> In1/In2 unchanged throughout. op_valid falls and in_ready rises on the op_ack edge. A second pair (A word0 = 7, B word0 = 9) then loads correctly.
4. Load A fully and B words 0..4, then pulse clear with in_valid = 1 -> the word in the clear cycle is dropped, In1 = In2 = 0, busy = 0. A fresh full load then completes normally.
5. Assert rstn low asynchronously (between clock edges) mid-LOAD_B -> all outputs go to reset values immediately. in_ready = 1 on the first edge after release.
6. Assert op_ack and clear together in HOLD -> clear behaviour wins: operands zeroed, state LOAD_A.

Source files
------------

// File: rtl/operand_loader.sv
// Streams two OP_W-bit operands in as WORD_W-bit words, least-significant first,
// and presents them together with op_valid until the consumer acknowledges.
module operand_loader #(
    parameter int WORD_W = 32,
    parameter int OP_W   = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [OP_W-1:0]   In1,
    output logic [OP_W-1:0]   In2,
    output logic              op_valid,
    input  logic              op_ack,
    output logic              busy
);

    localparam int NWORDS = OP_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic             accept;
    logic             last;

    assign accept = in_valid & in_ready & ~clear;
    assign last   = (word_cnt == LAST);
    assign busy   = (state == LOAD_A && word_cnt != '0) || (state == LOAD_B);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= LOAD_A;
            word_cnt <= '0;
            In1      <= '0;
            In2      <= '0;
            op_valid <= 1'b0;
            in_ready <= 1'b0;
        end else if (clear) begin
            state    <= LOAD_A;
            word_cnt <= '0;
            In1      <= '0;
            In2      <= '0;
            op_valid <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case (state)
                LOAD_A: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        In1[int'(word_cnt)*WORD_W +: WORD_W] <= in_data;
                        if (last) begin
                            word_cnt <= '0;
                            state    <= LOAD_B;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        In2[int'(word_cnt)*WORD_W +: WORD_W] <= in_data;
                        if (last) begin
                            word_cnt <= '0;
                            state    <= HOLD;
                            op_valid <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Operands stay frozen; incoming words are ignored here.
                    if (op_ack) begin
                        state    <= LOAD_A;
                        op_valid <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= LOAD_A;
                    word_cnt <= '0;
                    op_valid <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: streaming, stalls, hold, clear,
// asynchronous reset and clear-versus-ack priority.
module tb_operand_loader;

    localparam int WORD_W = 32;
    localparam int OP_W   = 1024;
    localparam int NW     = OP_W / WORD_W;

    logic              clk = 1'b0;
    logic              rstn;
    logic              clear;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   In1;
    logic [OP_W-1:0]   In2;
    logic              op_valid;
    logic              op_ack;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [OP_W-1:0]   a_val;
    logic [OP_W-1:0]   b_val;
    logic [2*OP_W-1:0] prod;

    operand_loader #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .In1      (In1),
        .In2      (In2),
        .op_valid (op_valid),
        .op_ack   (op_ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Wide values: the report shows the low 64 bits only.
    task automatic chkw(input string tag, input logic [OP_W-1:0] obs,
                        input logic [OP_W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed(lo64)=%0h expected(lo64)=%0h",
                   tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic [OP_W-1:0] v, input int first,
                          input int n, input bit gap);
        for (int k = first; k < first + n; k++) begin
            in_data  = v[k*WORD_W +: WORD_W];
            in_valid = 1'b1;
            tick();
            if (gap) begin
                in_valid = 1'b0;
                in_data  = '0;
                tick();
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic ack();
        op_ack = 1'b1;
        tick();
        op_ack = 1'b0;
    endtask

    initial begin
        rstn     = 1'b0;
        clear    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        op_ack   = 1'b0;

        // Reset state
        #12;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_op_valid", op_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_In1", In1, '0);
        chkw("rst_In2", In2, '0);
        rstn = 1'b1;
        #1;
        chk1("pre_edge_ready", in_ready, 1'b0);
        tick();
        chk1("post_rst_ready", in_ready, 1'b1);

        // 1: back-to-back stream, 33 x 44
        a_val = OP_W'(33);
        b_val = OP_W'(44);
        stream(a_val, 0, 1, 1'b0);
        chk1("t1_busy_first", busy, 1'b1);
        stream(a_val, 1, NW - 1, 1'b0);
        chk1("t1_busy_a_done", busy, 1'b1);
        chk1("t1_ready_b", in_ready, 1'b1);
        stream(b_val, 0, NW - 1, 1'b0);
        chk1("t1_no_valid_early", op_valid, 1'b0);
        stream(b_val, NW - 1, 1, 1'b0);
        chk1("t1_op_valid", op_valid, 1'b1);
        chk1("t1_in_ready", in_ready, 1'b0);
        chk1("t1_busy_hold", busy, 1'b0);
        chkw("t1_In1", In1, a_val);
        chkw("t1_In2", In2, b_val);
        prod = In1 * In2;
        chkw("t1_product", prod[OP_W-1:0], OP_W'(1452));
        chkw("t1_product_hi", prod[2*OP_W-1:OP_W], '0);

        // 3: HOLD ignores traffic, then ack
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        chkw("t3_In1_frozen", In1, a_val);
        chkw("t3_In2_frozen", In2, b_val);
        chk1("t3_still_valid", op_valid, 1'b1);
        ack();
        chk1("t3_ack_valid", op_valid, 1'b0);
        chk1("t3_ack_ready", in_ready, 1'b1);
        chkw("t3_In1_kept", In1, a_val);
        a_val = OP_W'(7);
        b_val = OP_W'(9);
        stream(a_val, 0, NW, 1'b0);
        stream(b_val, 0, NW, 1'b0);
        chk1("t3_pair2_valid", op_valid, 1'b1);
        chkw("t3_pair2_In1", In1, a_val);
        chkw("t3_pair2_In2", In2, b_val);
        ack();

        // 2: in_valid low on every other cycle
        a_val = OP_W'(33);
        b_val = OP_W'(44);
        stream(a_val, 0, NW, 1'b1);
        stream(b_val, 0, NW - 1, 1'b1);
        chk1("t2_no_valid_early", op_valid, 1'b0);
        in_data  = b_val[(NW-1)*WORD_W +: WORD_W];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk1("t2_op_valid", op_valid, 1'b1);
        chkw("t2_In1", In1, a_val);
        chkw("t2_In2", In2, b_val);
        ack();

        // 4: clear mid-B drops the offered word
        for (int k = 0; k < NW; k++) begin
            a_val[k*WORD_W +: WORD_W] = WORD_W'(k + 1);
            b_val[k*WORD_W +: WORD_W] = WORD_W'(32'h100 + k);
        end
        stream(a_val, 0, NW, 1'b0);
        stream(b_val, 0, 5, 1'b0);
        chkw("t4_partial_b", In2, OP_W'({32'h104, 32'h103, 32'h102,
                                          32'h101, 32'h100}));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chkw("t4_clr_In1", In1, '0);
        chkw("t4_clr_In2", In2, '0);
        chk1("t4_clr_busy", busy, 1'b0);
        chk1("t4_clr_ready", in_ready, 1'b1);
        tick();
        chk1("t4_clr_no_word", busy, 1'b0);
        stream(a_val, 0, NW, 1'b0);
        stream(b_val, 0, NW, 1'b0);
        chk1("t4_fresh_valid", op_valid, 1'b1);
        chkw("t4_fresh_In1", In1, a_val);
        chkw("t4_fresh_In2", In2, b_val);

        // 6: clear beats op_ack in HOLD
        op_ack = 1'b1;
        clear  = 1'b1;
        tick();
        op_ack = 1'b0;
        clear  = 1'b0;
        chk1("t6_valid", op_valid, 1'b0);
        chk1("t6_ready", in_ready, 1'b1);
        chkw("t6_In1", In1, '0);
        chkw("t6_In2", In2, '0);
        stream(a_val, 0, 1, 1'b0);
        chkw("t6_load_a", In1, OP_W'(1));

        // 5: asynchronous reset mid-LOAD_B
        stream(a_val, 1, NW - 1, 1'b0);
        stream(b_val, 0, 3, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        chk1("t5_rst_ready", in_ready, 1'b0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk1("t5_rst_valid", op_valid, 1'b0);
        chkw("t5_rst_In1", In1, '0);
        chkw("t5_rst_In2", In2, '0);
        #2;
        rstn = 1'b1;
        tick();
        chk1("t5_ready_after", in_ready, 1'b1);
        a_val = OP_W'(33);
        b_val = OP_W'(44);
        stream(a_val, 0, NW, 1'b0);
        stream(b_val, 0, NW, 1'b0);
        chk1("t5_reload_valid", op_valid, 1'b1);
        chkw("t5_reload_In2", In2, b_val);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
